active_mapper_tu: RTL

- Parametrised, multi-lane successor of the single-lane active-symbol mapper in the DisplayPort SST main-link TX path.
- Sits between the lane steering logic (upstream) and the scrambler/encoder (downstream).
- Builds complete Transfer Units (TUs) itself from a programmed valid-symbol count, rather than following an external per-cycle scheduler state. Each TU is: N data cycles, then stuffing-start (SS), stuffing fill, stuffing-end (SE).
- Applies the same symbol to all lanes in parallel, pulls data through a ready/valid handshake, and flags data underflow.

---
 rtl/active_mapper_tu_if.sv | 23 ++
 rtl/active_mapper_tu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/active_mapper_tu_if.sv
// Main-link stream bundle: steered beats in from lane steering, mapped symbols out
// towards the scrambler/encoder.
interface active_mapper_tu_if #(
    parameter int LANES = 4
);
    logic [LANES*8-1:0] main_steered;
    logic               main_valid;
    logic               main_ready;
    logic [LANES*8-1:0] am_active_symbol;
    logic [LANES-1:0]   am_control_sym_flag;
    logic               am_valid;
    logic               am_tu_start;

    modport slave (
        input  main_steered, main_valid,
        output main_ready, am_active_symbol, am_control_sym_flag, am_valid, am_tu_start
    );

    modport master (
        output main_steered, main_valid,
        input  main_ready, am_active_symbol, am_control_sym_flag, am_valid, am_tu_start
    );
endinterface

// File: rtl/active_mapper_tu.sv
// Multi-lane DP SST active-symbol mapper: self-timed Transfer Units of N data
// cycles followed by SS / fill / SE, same symbol class on every lane.
module active_mapper_tu_lane #(
    parameter logic [7:0] SS_SYM    = 8'hFA,
    parameter logic [7:0] SE_SYM    = 8'hFF,
    parameter logic [7:0] STUFF_SYM = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       use_data,
    input  logic       ctrl,
    input  logic       ctrl_se,
    input  logic [7:0] data,
    output logic [7:0] sym,
    output logic       flag
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym  <= STUFF_SYM;
            flag <= 1'b0;
        end else begin
            flag <= ctrl;
            if (use_data)  sym <= data;
            else if (ctrl) sym <= ctrl_se ? SE_SYM : SS_SYM;
            else           sym <= STUFF_SYM;
        end
    end
endmodule

module active_mapper_tu #(
    parameter int         LANES     = 4,
    parameter int         TU_SIZE   = 64,
    parameter logic [7:0] SS_SYM    = 8'hFA,
    parameter logic [7:0] SE_SYM    = 8'hFF,
    parameter logic [7:0] STUFF_SYM = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 am_en,
    input  logic [6:0]           tu_valid_syms,
    input  logic                 underflow_clr,
    output logic                 am_underflow,
    active_mapper_tu_if.slave    bus
);
    localparam int         CW      = $clog2(TU_SIZE);
    localparam logic [6:0] TU_N    = 7'(TU_SIZE);
    localparam logic [6:0] TU_LAST = 7'(TU_SIZE - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_SS   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_SE   = 3'd4;

    logic [2:0]    state, state_nx;
    logic [CW-1:0] tu_cnt, cnt_nx;
    logic [6:0]    n_lat, n_clamped;
    logic [6:0]    cnt_x, cnt_inc;
    logic          latch_n;

    assign cnt_x   = {{(7-CW){1'b0}}, tu_cnt};
    assign cnt_inc = cnt_x + 7'd1;

    // N == TU_SIZE-1 would leave room for SS but not SE, so it is pulled down by one.
    always_comb begin
        n_clamped = tu_valid_syms;
        if (tu_valid_syms == 7'd0)         n_clamped = 7'd1;
        else if (tu_valid_syms == TU_LAST) n_clamped = TU_LAST - 7'd1;
        else if (tu_valid_syms > TU_N)     n_clamped = TU_N;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = tu_cnt + CW'(1);
        latch_n  = 1'b0;
        if (!am_en) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                    latch_n  = 1'b1;
                end
                S_DATA: begin
                    if (cnt_x == TU_LAST) begin
                        cnt_nx  = '0;
                        latch_n = 1'b1;
                    end else if (cnt_inc == n_lat) begin
                        state_nx = S_SS;
                    end
                end
                S_SS:   state_nx = (cnt_inc == TU_LAST) ? S_SE : S_FILL;
                S_FILL: if (cnt_inc == TU_LAST) state_nx = S_SE;
                S_SE: begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                    latch_n  = 1'b1;
                end
                default: begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            tu_cnt <= '0;
            n_lat  <= 7'd0;
        end else begin
            state  <= state_nx;
            tu_cnt <= cnt_nx;
            if (latch_n) n_lat <= n_clamped;
        end
    end

    // The IDLE cycle that latches N is set-up only; TU output starts with the first DATA cycle.
    logic src_act, in_data, use_data, ctrl, ufl_evt;
    assign src_act  = am_en & (state != S_IDLE);
    assign in_data  = am_en & (state == S_DATA);
    assign use_data = in_data & bus.main_valid;
    assign ctrl     = src_act & ((state == S_SS) | (state == S_SE));
    assign ufl_evt  = in_data & ~bus.main_valid;
    assign bus.main_ready = in_data;

    logic [LANES-1:0][7:0] sym_q;
    logic [LANES-1:0]      flag_q;
    logic                  vld_q, start_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        active_mapper_tu_lane #(
            .SS_SYM(SS_SYM), .SE_SYM(SE_SYM), .STUFF_SYM(STUFF_SYM)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .use_data (use_data),
            .ctrl     (ctrl),
            .ctrl_se  (state == S_SE),
            .data     (bus.main_steered[8*i +: 8]),
            .sym      (sym_q[i]),
            .flag     (flag_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q        <= 1'b0;
            start_q      <= 1'b0;
            am_underflow <= 1'b0;
        end else begin
            vld_q        <= src_act;
            start_q      <= src_act & (tu_cnt == '0);
            am_underflow <= ufl_evt | (am_underflow & ~underflow_clr);
        end
    end

    assign bus.am_active_symbol    = sym_q;
    assign bus.am_control_sym_flag = flag_q;
    assign bus.am_valid            = vld_q;
    assign bus.am_tu_start         = start_q;
endmodule
